ap_op_arbiter: RTL and testbench
================================

Name: ap_op_arbiter

Overview:
- Shares one multi-cycle operator (ap_addF32, ap_mulF32, ap_divF32, ap_sqrtF32, ap_mulI, ap_divS, or any unit with the same (clk, rst, a, b, result, ready) protocol) among PORTS requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Sequences the operator's reset/start and waits for its ready.
- Returns the captured result to the winning port with a one-cycle valid pulse.

Parameters:
WIDTH, 32, operand/result width in bits.
PORTS, 4, number of requesters (2..8).
IDX_W, 2, width of grant index; must be at least ceil(log2(PORTS)).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  PORTS  per-port request; held with operands stable until req_ack.
req_a  in  PORTS*WIDTH  packed operand A; port p at bits [p*WIDTH +: WIDTH].
req_b  in  PORTS*WIDTH  packed operand B, same packing.
req_ack  out  PORTS  one-hot, one-cycle acceptance pulse.
resp_valid  out  PORTS  one-hot, one-cycle result pulse to the granted port.
resp_data  out  WIDTH  result; valid while resp_valid is nonzero, held until the next capture.
busy  out  1  high in LOAD and BUSY states.
op_rst  out  1  drives operator rst; high holds the operator in reset, low lets it compute.
op_a  out  WIDTH  operator operand A (registered).
op_b  out  WIDTH  operator operand B (registered).
op_result  in  WIDTH  operator result.
op_ready  in  1  operator done; op_result is valid while op_ready is high and op_rst is low.

Behaviour:
- Reset (async, immediate): state=IDLE, op_rst=1, op_a=op_b=0, req_ack=0, resp_valid=0, resp_data=0, busy=0, grant=0, rr_ptr=PORTS-1 so port 0 has first priority.
- Operator contract: operands must be stable for at least one edge with op_rst=1 before op_rst falls. op_ready is sampled only in BUSY and ignored in every other state.
- States: IDLE, LOAD, BUSY.
- IDLE: op_rst=1.
  - If any req_valid bit is set, select the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo PORTS.
  - At that edge: grant<=winner, rr_ptr<=winner, op_a/op_b<=winner's operands, req_ack<=onehot(winner), state<=LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle): req_ack[grant]=1, op_rst still 1. Next edge: req_ack<=0, op_rst<=0, state<=BUSY.
- BUSY: op_rst=0. Stays in BUSY with no timeout until op_ready=1 is sampled. At that edge:
  - resp_data<=op_result;
  - resp_valid<=onehot(grant) for exactly one cycle;
  - op_rst<=1;
  - state<=IDLE.
- The IDLE cycle carrying resp_valid may itself grant a new request; resp_valid and a new grant decision coexist.
- req_valid is ignored outside IDLE. The requester may drop or change req_valid/operands on the edge that ends its req_ack cycle.
- A port re-asserting req_valid immediately after its ack competes normally. Its earlier response is always delivered before its next grant, because operations are strictly serialised.
- Timing: grant edge G; req_ack high in cycle G+1; op_rst low from G+2. If op_ready is first sampled high at edge G+1+L (L≥1), resp_valid is high in cycle G+1+L and the next grant can occur at that same edge. Minimum period is 3 cycles per operation (operator ready on first BUSY edge).
- Fairness: with all ports continuously requesting, grants go 0,1,...,PORTS-1,0,...; no port waits more than PORTS-1 other operations.
- Reset mid-operation (LOAD or BUSY): in-flight request is discarded, no resp_valid is issued, op_rst rises immediately; the requester must re-request.
- Unused req_valid bits above PORTS do not exist; no X propagation from unselected operand slices.

Test Plan:
- Single request, stub operator latency 4: port 1 requests a=0x11, b=0x22 at cycle 0 -> req_ack=4'b0010 in cycle 1; op_rst low cycles 2..5; resp_valid=4'b0010 with resp_data=stub(0x11,0x22) in exactly one cycle; busy low afterwards.
- ap_addF32 as operator: port 2 requests 0x3F800000 + 0x40000000 -> resp_valid[2] pulses once with resp_data=0x40400000 (3.0); ap_divS(32): -1234124124 / 134123 -> resp_data equals signed quotient -9201.
- All four ports request simultaneously after reset and re-request after each ack -> ack order 0,1,2,3,0,1; each resp_valid goes to the port acked for that operation; no back-to-back duplicate grants.
- Fairness: port 3 requests continuously, port 0 asserts while port 3 is BUSY -> next grant is port 0 (pointer=3), then port 3.
- Zero-wait operator (op_ready tied high): 3 back-to-back requests from port 0 -> resp_valid every 3 cycles; op_rst low exactly one cycle per operation.
- Async rst asserted mid-BUSY (between edges) -> op_rst=1, busy=0, req_ack=0, resp_valid=0 immediately, no response for the lost request; after release, a port-0 request is granted first and completes correctly.

Source files
------------

// File: rtl/ap_op_arbiter.sv
// Round-robin front end that time-shares one multi-cycle operator among PORTS requesters.
// Latency: grant edge, 1 LOAD cycle, then operator latency; requests are held off (no ack) while busy.
module ap_op_arbiter #(
  parameter int WIDTH = 32,
  parameter int PORTS = 4,
  parameter int IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0]       req_valid,
  input  logic [PORTS*WIDTH-1:0] req_a,
  input  logic [PORTS*WIDTH-1:0] req_b,
  output logic [PORTS-1:0]       req_ack,
  output logic [PORTS-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   busy,
  output logic                   op_rst,
  output logic [WIDTH-1:0]       op_a,
  output logic [WIDTH-1:0]       op_b,
  input  logic [WIDTH-1:0]       op_result,
  input  logic                   op_ready
);

  if (IDX_W < $clog2(PORTS)) begin : g_idx_w_check
    $error("ap_op_arbiter: IDX_W is too narrow to index PORTS requesters");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  winner;
  logic              win_vld;
  logic [PORTS-1:0]  grant_oh;
  logic [WIDTH-1:0]  a_slot [PORTS];
  logic [WIDTH-1:0]  b_slot [PORTS];

  assign grant_oh = {{(PORTS-1){1'b0}}, 1'b1} << grant;

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      a_slot[p] = req_a[p*WIDTH +: WIDTH];
      b_slot[p] = req_b[p*WIDTH +: WIDTH];
    end
  end

  // First requester after the last winner, wrapping modulo PORTS.
  always_comb begin : rr_search
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    winner   = rr_ptr;
    win_vld  = 1'b0;
    for (int i = 1; i <= PORTS; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= PORTS) begin
        cand = cand - PORTS;
      end
      cand_idx = IDX_W'(cand);
      if (!win_vld && req_valid[cand_idx]) begin
        win_vld = 1'b1;
        winner  = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_vld) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_BUSY;
      S_BUSY:  if (op_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operator is held in reset everywhere except BUSY, so operands settle before it runs.
  always_comb begin
    op_rst  = 1'b1;
    busy    = 1'b0;
    req_ack = '0;
    case (state)
      S_LOAD: begin
        busy    = 1'b1;
        req_ack = grant_oh;
      end
      S_BUSY: begin
        busy   = 1'b1;
        op_rst = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      rr_ptr     <= IDX_W'(PORTS-1);
      op_a       <= '0;
      op_b       <= '0;
      resp_data  <= '0;
      resp_valid <= '0;
    end else begin
      resp_valid <= '0;
      if (state == S_IDLE && win_vld) begin
        grant  <= winner;
        rr_ptr <= winner;
        op_a   <= a_slot[winner];
        op_b   <= b_slot[winner];
      end
      if (state == S_BUSY && op_ready) begin
        resp_data  <= op_result;
        resp_valid <= grant_oh;
      end
    end
  end

endmodule

// File: tb/tb_ap_op_arbiter.sv
// Bench for ap_op_arbiter: stub operator with programmable latency, vector table plus stream sequences.
`timescale 1ns/1ps
module tb_ap_op_arbiter;
  localparam int WIDTH = 32;
  localparam int PORTS = 4;
  localparam int IDX_W = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [PORTS-1:0]       req_valid;
  logic [PORTS*WIDTH-1:0] req_a;
  logic [PORTS*WIDTH-1:0] req_b;
  logic [PORTS-1:0]       req_ack;
  logic [PORTS-1:0]       resp_valid;
  logic [WIDTH-1:0]       resp_data;
  logic                   busy;
  logic                   op_rst;
  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic [WIDTH-1:0]       op_result;
  logic                   op_ready;

  always #5 clk = ~clk;

  ap_op_arbiter #(.WIDTH(WIDTH), .PORTS(PORTS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
    .op_rst(op_rst), .op_a(op_a), .op_b(op_b), .op_result(op_result), .op_ready(op_ready)
  );

  // Stub operator: mode 0 computes a + 2*b, mode 1 signed a / b; latency 0 ties ready high.
  int          stub_lat  = 4;
  int          stub_mode = 0;
  logic [31:0] stub_cnt  = '0;

  function automatic logic [31:0] model(input int mode, input logic [31:0] a, input logic [31:0] b);
    if (mode == 1) return (b == 32'h0) ? 32'h0 : 32'($signed(a) / $signed(b));
    return a + (b << 1);
  endfunction

  always @(posedge clk) begin
    if (op_rst) stub_cnt <= '0;
    else        stub_cnt <= stub_cnt + 32'd1;
  end

  assign op_ready  = (stub_lat == 0) ? 1'b1 : (!op_rst && (stub_cnt >= 32'(stub_lat - 1)));
  assign op_result = op_ready ? model(stub_mode, op_a, op_b) : 32'hDEADBEEF;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expectation pushed at each ack, popped at each response.
  int          ack_log[$];
  int          ack_cyc[$];
  int          resp_cyc[$];
  int          exp_port_q[$];
  logic [31:0] exp_data_q[$];
  int          cyc = 0;
  int          op_low_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    int          p;
    logic [31:0] ed;
    if (!rst) begin
      if (!op_rst) op_low_cnt++;
      if (req_ack != '0) begin
        p = 0;
        for (int i = 0; i < PORTS; i++) if (req_ack[i]) p = i;
        chk("ack_onehot", 64'($countones(req_ack)), 64'd1);
        ack_log.push_back(p);
        ack_cyc.push_back(cyc);
        exp_port_q.push_back(p);
        exp_data_q.push_back(model(stub_mode, req_a[p*WIDTH +: WIDTH], req_b[p*WIDTH +: WIDTH]));
      end
      if (resp_valid != '0) begin
        resp_cyc.push_back(cyc);
        if (exp_port_q.size() == 0) begin
          chk("resp_spurious", 64'(resp_valid), 64'd0);
        end else begin
          p  = exp_port_q.pop_front();
          ed = exp_data_q.pop_front();
          chk("sb_resp_port", 64'(resp_valid), 64'd1 << p);
          chk("sb_resp_data", 64'(resp_data), 64'(ed));
        end
      end
    end
  end

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          mode;
    logic [31:0] exp;
    int          resp_at;
    int          low;
  } vec_t;

  vec_t vecs[5];

  task automatic do_reset();
    req_valid = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    exp_port_q.delete();
    exp_data_q.delete();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((busy || exp_port_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk(name, 64'(exp_port_q.size()), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int low;
    bit got;
    stub_lat  = v.lat;
    stub_mode = v.mode;
    @(posedge clk); #1;
    req_a[v.port*WIDTH +: WIDTH] = v.a;
    req_b[v.port*WIDTH +: WIDTH] = v.b;
    req_valid[v.port] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("vec_ack", 64'(req_ack), 64'd1 << v.port);
    chk("vec_busy_load", 64'(busy), 64'd1);
    chk("vec_op_rst_load", 64'(op_rst), 64'd1);
    chk("vec_op_a", 64'(op_a), 64'(v.a));
    chk("vec_op_b", 64'(op_b), 64'(v.b));
    @(posedge clk); #1;
    req_valid = '0;
    n = 1; low = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (!op_rst) low++;
      if (resp_valid != '0) begin
        got = 1'b1;
        chk("vec_resp_cycle", 64'(n), 64'(v.resp_at));
        chk("vec_resp_port", 64'(resp_valid), 64'd1 << v.port);
        chk("vec_resp_data", 64'(resp_data), 64'(v.exp));
        chk("vec_op_rst_low", 64'(low), 64'(v.low));
      end
    end
    chk("vec_resp_seen", 64'(got), 64'd1);
    @(negedge clk);
    chk("vec_resp_pulse", 64'(resp_valid), 64'd0);
    chk("vec_busy_after", 64'(busy), 64'd0);
    chk("vec_data_held", 64'(resp_data), 64'(v.exp));
  endtask

  // Ports in start_mask request continuously (operands bumped after each ack); join_mask joins at
  // loop cycle join_at; once_mask ports drop after their first ack; all stop after n_acks grants.
  task automatic stream(input logic [PORTS-1:0] start_mask, input logic [PORTS-1:0] join_mask,
                        input int join_at, input logic [PORTS-1:0] once_mask, input int n_acks);
    int               base;
    int               n;
    logic [PORTS-1:0] ack_now;
    base = ack_log.size();
    n    = 0;
    @(posedge clk); #1;
    req_valid = start_mask;
    while (ack_log.size() < base + n_acks && n < 300) begin
      @(negedge clk);
      n++;
      ack_now = req_ack;
      @(posedge clk); #1;
      if (n == join_at) req_valid = req_valid | join_mask;
      for (int p = 0; p < PORTS; p++) begin
        if (ack_now[p]) begin
          req_a[p*WIDTH +: WIDTH] = req_a[p*WIDTH +: WIDTH] + 32'h10;
          if (once_mask[p] || ack_log.size() >= base + n_acks) req_valid[p] = 1'b0;
        end
      end
    end
    chk("stream_budget", 64'(n < 300), 64'd1);
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rbase;
    int lbase;
    int n;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;

    vecs[0] = '{1, 32'h0000_0011, 32'h0000_0022, 4, 0, 32'h0000_0055, 6, 4};
    vecs[1] = '{2, 32'h3F80_0000, 32'h4000_0000, 2, 0, 32'hBF80_0000, 4, 2};
    vecs[2] = '{0, 32'hB670_C2A4, 32'h0002_0BEB, 3, 1, 32'hFFFF_DC0F, 5, 3};
    vecs[3] = '{3, 32'hFFFF_FFFF, 32'h0000_0001, 1, 0, 32'h0000_0001, 3, 1};
    vecs[4] = '{0, 32'h0000_1234, 32'h0000_0000, 0, 0, 32'h0000_1234, 3, 1};

    @(negedge clk);
    chk("rst_op_rst", 64'(op_rst), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ack", 64'(req_ack), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_op_a", 64'(op_a), 64'd0);
    chk("rst_op_b", 64'(op_b), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    drain("vec_drain");

    // All ports continuously requesting from reset: strict rotation starting at port 0.
    do_reset();
    stub_lat = 2; stub_mode = 0;
    for (int p = 0; p < PORTS; p++) begin
      req_a[p*WIDTH +: WIDTH] = 32'h100 * (p + 1);
      req_b[p*WIDTH +: WIDTH] = 32'(p);
    end
    base = ack_log.size();
    stream(4'b1111, 4'b0000, 0, 4'b0000, 6);
    drain("rr_drain");
    for (int k = 0; k < 6; k++) chk("rr_order", 64'(ack_log[base+k]), 64'(k % 4));

    // Port 3 streaming, port 0 joins mid-BUSY and must win the next slot.
    do_reset();
    stub_lat = 4;
    base = ack_log.size();
    stream(4'b1000, 4'b0001, 3, 4'b0001, 3);
    drain("fair_drain");
    chk("fair_first", 64'(ack_log[base]), 64'd3);
    chk("fair_second", 64'(ack_log[base+1]), 64'd0);
    chk("fair_third", 64'(ack_log[base+2]), 64'd3);

    // Ready tied high: three back-to-back operations, one every 3 cycles.
    stub_lat = 0;
    base  = ack_log.size();
    rbase = resp_cyc.size();
    lbase = op_low_cnt;
    stream(4'b0001, 4'b0000, 0, 4'b0000, 3);
    drain("zw_drain");
    chk("zw_resp_count", 64'(resp_cyc.size() - rbase), 64'd3);
    chk("zw_op_rst_low", 64'(op_low_cnt - lbase), 64'd3);
    for (int k = 1; k < 3; k++) begin
      chk("zw_ack_period", 64'(ack_cyc[base+k] - ack_cyc[base+k-1]), 64'd3);
      chk("zw_resp_period", 64'(resp_cyc[rbase+k] - resp_cyc[rbase+k-1]), 64'd3);
    end

    // Asynchronous reset in the middle of BUSY discards the operation.
    stub_lat = 10; stub_mode = 0;
    @(posedge clk); #1;
    req_a[2*WIDTH +: WIDTH] = 32'h5;
    req_b[2*WIDTH +: WIDTH] = 32'h6;
    req_valid[2] = 1'b1;
    n = 0;
    while (req_ack[2] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arst_ack_seen", 64'(req_ack[2]), 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk); #3;
    chk("arst_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_op_rst", 64'(op_rst), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_req_ack", 64'(req_ack), 64'd0);
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    exp_port_q.delete();
    exp_data_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    rbase = resp_cyc.size();
    repeat (20) @(negedge clk);
    chk("arst_no_resp", 64'(resp_cyc.size() - rbase), 64'd0);
    stub_lat = 3;
    base = ack_log.size();
    req_a[0*WIDTH +: WIDTH] = 32'h7;
    req_b[0*WIDTH +: WIDTH] = 32'h9;
    req_a[3*WIDTH +: WIDTH] = 32'h70;
    req_b[3*WIDTH +: WIDTH] = 32'h90;
    stream(4'b1001, 4'b0000, 0, 4'b1001, 2);
    drain("arst_drain");
    chk("arst_first_grant", 64'(ack_log[base]), 64'd0);
    chk("arst_second_grant", 64'(ack_log[base+1]), 64'd3);

    chk("sb_empty", 64'(exp_port_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
